cruise_controller: RTL and testbench

//  Cruise-control sequencer for the dashboard velocity datapath. Captures a target speed and

---
 rtl/car_pkg.sv | 29 ++
 rtl/cruise_controller_if.sv | 31 +++
 rtl/cruise_controller_rise_detect.sv | 19 +
 rtl/cruise_controller.sv | 161 ++++++++++++++++
 tb/tb_cruise_controller.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/car_pkg.sv
// Shared vehicle constants: gear encoding, cruise state enum and cruise tuning values.
package car_pkg;

  localparam logic [3:0] GEAR_N = 4'd0;
  localparam logic [3:0] GEAR_1 = 4'd1;
  localparam logic [3:0] GEAR_2 = 4'd2;
  localparam logic [3:0] GEAR_3 = 4'd3;
  localparam logic [3:0] GEAR_4 = 4'd4;
  localparam logic [3:0] GEAR_5 = 4'd5;
  localparam logic [3:0] GEAR_R = 4'd6;

  typedef enum logic [1:0] {
    CC_OFF       = 2'd0,
    CC_STANDBY   = 2'd1,
    CC_HOLD      = 2'd2,
    CC_SUSPENDED = 2'd3
  } cc_state_e;

  localparam int unsigned CC_MIN_SPEED = 30;
  localparam int unsigned CC_MAX_SPEED = 100;
  localparam int unsigned CC_DEADBAND  = 2;
  localparam int unsigned CC_STEP      = 5;

  // Cruise may only engage in a forward gear; neutral and reverse are excluded.
  function automatic logic gear_is_forward(input logic [3:0] gear);
    return (gear >= GEAR_1) && (gear <= GEAR_5);
  endfunction

endpackage

// File: rtl/cruise_controller_if.sv
// Driver-side controls, velocity feedback and command outputs of the cruise controller.
interface cruise_controller_if;
  logic       tick;
  logic       cruise_on;
  logic       set_btn;
  logic       resume_btn;
  logic       cancel_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic       drv_accel;
  logic       drv_brake;
  logic       clutch;
  logic [3:0] gear;
  logic [7:0] velocity;
  logic       accel_cmd;
  logic       brake_cmd;
  logic [7:0] set_speed;
  logic [1:0] cruise_state;

  modport master (
    output tick, cruise_on, set_btn, resume_btn, cancel_btn, inc_btn, dec_btn,
    output drv_accel, drv_brake, clutch, gear, velocity,
    input  accel_cmd, brake_cmd, set_speed, cruise_state
  );

  modport slave (
    input  tick, cruise_on, set_btn, resume_btn, cancel_btn, inc_btn, dec_btn,
    input  drv_accel, drv_brake, clutch, gear, velocity,
    output accel_cmd, brake_cmd, set_speed, cruise_state
  );
endinterface

// File: rtl/cruise_controller_rise_detect.sv
// One-bit rising-edge detector: remembers last cycle's level, flags a 0->1 transition.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // History register, updated every cycle so a held level yields a single event.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/cruise_controller.sv
// Cruise-control sequencer: captures a target speed and issues accel/brake requests
// to hold velocity within a deadband of it.
module cruise_controller
  import car_pkg::*;
#(
  parameter int unsigned MIN_SPEED = CC_MIN_SPEED,
  parameter int unsigned MAX_SPEED = CC_MAX_SPEED,
  parameter int unsigned DEADBAND  = CC_DEADBAND,
  parameter int unsigned STEP      = CC_STEP
) (
  input logic           clk,
  input logic           rst,
  cruise_controller_if.slave bus
);

  localparam logic [8:0] MIN9  = 9'(MIN_SPEED);
  localparam logic [8:0] MAX9  = 9'(MAX_SPEED);
  localparam logic [8:0] DB9   = 9'(DEADBAND);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] MIN8  = 8'(MIN_SPEED);
  localparam logic [7:0] MAX8  = 8'(MAX_SPEED);

  localparam int BTN_SET    = 0;
  localparam int BTN_RESUME = 1;
  localparam int BTN_CANCEL = 2;
  localparam int BTN_INC    = 3;
  localparam int BTN_DEC    = 4;

  logic [4:0] btn_vec;
  logic [4:0] btn_rise;

  assign btn_vec = {bus.dec_btn, bus.inc_btn, bus.cancel_btn, bus.resume_btn, bus.set_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_rise
      rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (btn_vec[gi]),
        .rise (btn_rise[gi])
      );
    end
  endgenerate

  cc_state_e  state_q, state_d;
  logic [7:0] set_speed_q, set_speed_d;
  logic       accel_q, accel_d;
  logic       brake_q, brake_d;

  // Arithmetic is done in 9 bits so velocity+DEADBAND and set_speed+STEP never wrap.
  logic [8:0] vel9, sp9, sp_inc9, sp_dec9;
  logic [7:0] capture_speed, inc_speed, dec_speed;
  logic       ok, suspend, tick_accel, tick_brake;

  assign vel9          = {1'b0, bus.velocity};
  assign sp9           = {1'b0, set_speed_q};
  assign sp_inc9       = sp9 + STEP9;
  assign sp_dec9       = sp9 - STEP9;
  assign capture_speed = (vel9 > MAX9) ? MAX8 : bus.velocity;
  assign inc_speed     = (sp_inc9 > MAX9) ? MAX8 : sp_inc9[7:0];
  assign dec_speed     = (sp9 < MIN9 + STEP9) ? MIN8 : sp_dec9[7:0];
  assign tick_accel    = (vel9 + DB9) < sp9;
  assign tick_brake    = vel9 > (sp9 + DB9);

  assign ok      = gear_is_forward(bus.gear) && (vel9 >= MIN9) && !bus.drv_brake && !bus.clutch;
  assign suspend = bus.drv_brake | bus.clutch | btn_rise[BTN_CANCEL] | !ok;

  // State, target and command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CC_OFF;
      set_speed_q <= 8'd0;
      accel_q     <= 1'b0;
      brake_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_speed_q <= set_speed_d;
      accel_q     <= accel_d;
      brake_q     <= brake_d;
    end
  end

  // Next-state, target update and command selection with master-enable priority.
  always_comb begin
    state_d     = state_q;
    set_speed_d = set_speed_q;
    accel_d     = accel_q;
    brake_d     = brake_q;

    if (!bus.cruise_on) begin
      state_d     = CC_OFF;
      set_speed_d = 8'd0;
      accel_d     = 1'b0;
      brake_d     = 1'b0;
    end else begin
      unique case (state_q)
        CC_OFF: begin
          state_d     = CC_STANDBY;
          set_speed_d = 8'd0;
          accel_d     = 1'b0;
          brake_d     = 1'b0;
        end

        CC_STANDBY: begin
          accel_d = 1'b0;
          brake_d = 1'b0;
          if (btn_rise[BTN_SET] && ok) begin
            set_speed_d = capture_speed;
            state_d     = CC_HOLD;
          end
        end

        CC_HOLD: begin
          if (suspend) begin
            state_d = CC_SUSPENDED;
            accel_d = 1'b0;
            brake_d = 1'b0;
          end else begin
            // Target adjustment: set beats resume beats inc/dec; resume is a no-op here.
            if (btn_rise[BTN_SET]) begin
              set_speed_d = capture_speed;
            end else if (!btn_rise[BTN_RESUME]) begin
              if (btn_rise[BTN_INC] && !btn_rise[BTN_DEC]) set_speed_d = inc_speed;
              else if (btn_rise[BTN_DEC] && !btn_rise[BTN_INC]) set_speed_d = dec_speed;
            end
            // Driver accel overrides immediately; otherwise commands refresh only on tick.
            if (bus.drv_accel) begin
              accel_d = 1'b1;
              brake_d = 1'b0;
            end else if (bus.tick) begin
              accel_d = tick_accel;
              brake_d = tick_brake;
            end
          end
        end

        CC_SUSPENDED: begin
          accel_d = 1'b0;
          brake_d = 1'b0;
          if (btn_rise[BTN_SET] && ok) begin
            set_speed_d = capture_speed;
            state_d     = CC_HOLD;
          end else if (btn_rise[BTN_RESUME] && ok && (set_speed_q != 8'd0)) begin
            state_d = CC_HOLD;
          end
        end

        default: begin
          state_d = CC_OFF;
        end
      endcase
    end
  end

  assign bus.accel_cmd    = accel_q;
  assign bus.brake_cmd    = brake_q;
  assign bus.set_speed    = set_speed_q;
  assign bus.cruise_state = state_q;

endmodule

// File: tb/tb_cruise_controller.sv
// Directed bench for cruise_controller with hand-computed expectations.
module tb_cruise_controller;
  import car_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cruise_controller_if bus ();

  cruise_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] B_SET    = 5'b00001;
  localparam logic [4:0] B_RESUME = 5'b00010;
  localparam logic [4:0] B_CANCEL = 5'b00100;
  localparam logic [4:0] B_INC    = 5'b01000;
  localparam logic [4:0] B_DEC    = 5'b10000;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
      $display("ok   %s: %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int sp, input int ac, input int br);
    check({tag, ".state"}, int'(bus.cruise_state), st);
    check({tag, ".set_speed"}, int'(bus.set_speed), sp);
    check({tag, ".accel"}, int'(bus.accel_cmd), ac);
    check({tag, ".brake"}, int'(bus.brake_cmd), br);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] v);
    bus.set_btn    = v[0];
    bus.resume_btn = v[1];
    bus.cancel_btn = v[2];
    bus.inc_btn    = v[3];
    bus.dec_btn    = v[4];
  endtask

  // Hold the button(s) for one clock, then release for one clock.
  task automatic press(input logic [4:0] v);
    set_btns(v);
    step();
    set_btns(5'b0);
    step();
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.tick      = 1'b0;
    bus.cruise_on = 1'b0;
    set_btns(5'b0);
    bus.drv_accel = 1'b0;
    bus.drv_brake = 1'b0;
    bus.clutch    = 1'b0;
    bus.gear      = GEAR_3;
    bus.velocity  = 8'd60;
    step();
    step();
    check_all("reset", 0, 0, 0, 0);

    // Enable, capture at 60, tick within deadband.
    rst = 1'b0;
    bus.cruise_on = 1'b1;
    step();
    check("enable.state", int'(bus.cruise_state), 1);
    press(B_SET);
    do_tick();
    check_all("set60", 2, 60, 0, 0);

    // Deadband decisions on tick.
    bus.velocity = 8'd55; do_tick();
    check_all("v55", 2, 60, 1, 0);
    bus.velocity = 8'd63; do_tick();
    check_all("v63", 2, 60, 0, 1);
    bus.velocity = 8'd61; do_tick();
    check_all("v61", 2, 60, 0, 0);
    bus.velocity = 8'd58; do_tick();
    check_all("v58_edge", 2, 60, 0, 0);
    bus.velocity = 8'd57; do_tick();
    check_all("v57", 2, 60, 1, 0);
    bus.velocity = 8'd63; step();
    check_all("no_tick_hold", 2, 60, 1, 0);
    bus.velocity = 8'd62; do_tick();
    check_all("v62_edge", 2, 60, 0, 0);

    // Brake pedal suspends; resume restores the stored target.
    bus.velocity = 8'd55; do_tick();
    bus.drv_brake = 1'b1; step();
    check_all("drv_brake", 3, 60, 0, 0);
    bus.drv_brake = 1'b0;
    bus.velocity  = 8'd50;
    press(B_RESUME);
    check_all("resume", 2, 60, 0, 0);

    // Driver accel override acts on a non-tick cycle.
    bus.velocity  = 8'd40;
    bus.drv_accel = 1'b1; step();
    check_all("override", 2, 60, 1, 0);
    bus.drv_accel = 1'b0;
    bus.velocity  = 8'd70; do_tick();
    check_all("v70", 2, 60, 0, 1);
    bus.drv_accel = 1'b1; step();
    check_all("override_brk", 2, 60, 1, 0);
    bus.drv_accel = 1'b0; step();
    check_all("override_rel", 2, 60, 1, 0);
    bus.velocity = 8'd60; do_tick();
    check_all("v60", 2, 60, 0, 0);

    // Cancel, then recapture and adjust target.
    press(B_CANCEL);
    check_all("cancel", 3, 60, 0, 0);
    bus.velocity = 8'd98;
    press(B_SET);
    check_all("set98", 2, 98, 0, 0);
    press(B_INC);
    check("inc1", int'(bus.set_speed), 100);
    press(B_INC);
    check("inc2_sat", int'(bus.set_speed), 100);
    press(B_INC | B_DEC);
    check("inc_dec_same", int'(bus.set_speed), 100);
    press(B_DEC);
    check("dec95", int'(bus.set_speed), 95);
    bus.velocity = 8'd120;
    press(B_SET);
    check("clamp120", int'(bus.set_speed), 100);
    do_tick();
    check_all("v120", 2, 100, 0, 1);
    bus.velocity = 8'd32;
    press(B_SET);
    check("set32", int'(bus.set_speed), 32);
    press(B_DEC);
    check("dec_floor", int'(bus.set_speed), 30);

    // Off clears; STANDBY refuses low speed and neutral.
    bus.cruise_on = 1'b0; step();
    check_all("off", 0, 0, 0, 0);
    bus.cruise_on = 1'b1; step();
    bus.velocity = 8'd20;
    press(B_SET);
    check_all("set_lowvel", 1, 0, 0, 0);
    bus.velocity = 8'd60;
    bus.gear     = GEAR_N;
    press(B_SET);
    check_all("set_neutral", 1, 0, 0, 0);
    bus.gear = GEAR_3;

    // Clutch beats a simultaneous set press.
    press(B_SET);
    check_all("set60b", 2, 60, 0, 0);
    bus.clutch = 1'b1;
    press(B_SET);
    check_all("clutch_set", 3, 60, 0, 0);
    bus.clutch = 1'b0;
    bus.cruise_on = 1'b0; step();
    check_all("off2", 0, 0, 0, 0);

    // Reset during HOLD with an active command.
    bus.cruise_on = 1'b1; step();
    press(B_SET);
    bus.velocity = 8'd55; do_tick();
    check_all("pre_rst", 2, 60, 1, 0);
    rst = 1'b1; step();
    check_all("rst_hold", 0, 0, 0, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
